// File: rtl/rn_rat_pkg.sv
// rtl/rn_rat_pkg.sv - shared widths and types for the rename alias table
`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

package rn_rat_pkg;
    localparam int REG_AW = `NCPU_REG_AW;
    localparam int PRF_AW = `NCPU_PRF_AW;
    localparam int NREG   = 1 << REG_AW;

    typedef logic [REG_AW-1:0] lreg_t;
    typedef logic [PRF_AW-1:0] preg_t;
endpackage

// File: rtl/rn_rat_if.sv
// rtl/rn_rat_if.sv - rename group, free-list, commit and output bundle
interface rn_rat_if
    import rn_rat_pkg::*;
#(
    parameter int IW = 2,
    parameter int CW = 2
) ();
    logic [IW-1:0]        rn_valid;
    logic                 rn_ready;
    logic [IW*REG_AW-1:0] rn_lrs1;
    logic [IW*REG_AW-1:0] rn_lrs2;
    logic [IW*REG_AW-1:0] rn_lrd;
    logic [IW-1:0]        rn_lrd_we;
    logic [IW*PRF_AW-1:0] fl_prd;
    logic                 fl_stall_req;
    logic [IW-1:0]        pop;
    logic [IW-1:0]        lrd_we;
    logic                 rollback;
    logic [CW-1:0]        cmt_fire;
    logic [CW-1:0]        cmt_prd_we;
    logic [CW*REG_AW-1:0] cmt_lrd;
    logic [CW*PRF_AW-1:0] cmt_prd;
    logic                 out_valid;
    logic                 out_ready;
    logic [IW*PRF_AW-1:0] out_prs1;
    logic [IW*PRF_AW-1:0] out_prs2;
    logic [IW*PRF_AW-1:0] out_prd;
    logic [IW*PRF_AW-1:0] out_pfree;
    logic [IW-1:0]        out_prd_we;
    logic [IW-1:0]        out_slot_valid;

    modport master (
        output rn_valid, rn_lrs1, rn_lrs2, rn_lrd, rn_lrd_we, fl_prd, fl_stall_req,
               rollback, cmt_fire, cmt_prd_we, cmt_lrd, cmt_prd, out_ready,
        input  rn_ready, pop, lrd_we, out_valid, out_prs1, out_prs2, out_prd,
               out_pfree, out_prd_we, out_slot_valid
    );

    modport slave (
        input  rn_valid, rn_lrs1, rn_lrs2, rn_lrd, rn_lrd_we, fl_prd, fl_stall_req,
               rollback, cmt_fire, cmt_prd_we, cmt_lrd, cmt_prd, out_ready,
        output rn_ready, pop, lrd_we, out_valid, out_prs1, out_prs2, out_prd,
               out_pfree, out_prd_we, out_slot_valid
    );
endinterface

// File: rtl/rn_rat_bypass.sv
// rtl/rn_rat_bypass.sv - slot 1 source and pfree forwarding from slot 0
module rn_rat_bypass
    import rn_rat_pkg::*;
(
    input  logic       valid0,
    input  logic [1:0] lrd_we,
    input  lreg_t      lrd0,
    input  lreg_t      lrd1,
    input  lreg_t      lrs1_1,
    input  lreg_t      lrs2_1,
    input  preg_t      fl_prd0,
    input  preg_t      rd_prs1_1,
    input  preg_t      rd_prs2_1,
    input  preg_t      rd_pfree_1,
    output preg_t      prs1_1,
    output preg_t      prs2_1,
    output preg_t      pfree_1
);
    logic slot0_writes;

    // A slot 0 write is not yet in the table, so slot 1 must see slot 0's new PR
    always_comb begin
        slot0_writes = valid0 & lrd_we[0];
        prs1_1  = (slot0_writes && (lrd0 == lrs1_1)) ? fl_prd0 : rd_prs1_1;
        prs2_1  = (slot0_writes && (lrd0 == lrs2_1)) ? fl_prd0 : rd_prs2_1;
        pfree_1 = '0;
        if (lrd_we[1]) begin
            pfree_1 = (lrd_we[0] && (lrd0 == lrd1)) ? fl_prd0 : rd_pfree_1;
        end
    end
endmodule

// File: rtl/rn_rat.sv
// rtl/rn_rat.sv - speculative/architectural register alias table for rename
module rn_rat
    import rn_rat_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_COMMIT_WIDTH = 1
) (
    input logic   clk,
    input logic   rst,
    rn_rat_if.slave bus
);
    localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH;

    preg_t srat_q [NREG];
    preg_t srat_d [NREG];
    preg_t arat_q [NREG];
    preg_t arat_d [NREG];

    logic                 out_valid_q, out_valid_d;
    logic [IW*PRF_AW-1:0] out_prs1_q, out_prs1_d;
    logic [IW*PRF_AW-1:0] out_prs2_q, out_prs2_d;
    logic [IW*PRF_AW-1:0] out_prd_q, out_prd_d;
    logic [IW*PRF_AW-1:0] out_pfree_q, out_pfree_d;
    logic [IW-1:0]        out_prd_we_q, out_prd_we_d;
    logic [IW-1:0]        out_slot_valid_q, out_slot_valid_d;

    lreg_t      lrs1 [IW];
    lreg_t      lrs2 [IW];
    lreg_t      lrd [IW];
    preg_t      fl [IW];
    preg_t      rd_prs1 [IW];
    preg_t      rd_prs2 [IW];
    preg_t      rd_pfree [IW];
    preg_t      prd_n [IW];
    logic [IW-1:0] lrd_we;
    logic [IW-1:0] pop;
    logic       rn_ready;
    logic       in_fire;
    preg_t      pfree_0;
    preg_t      prs1_1, prs2_1, pfree_1;

    // Handshake, r0 masking and combinational sRAT lookup per slot
    always_comb begin
        rn_ready = (~out_valid_q | bus.out_ready) & ~bus.fl_stall_req & ~bus.rollback;
        in_fire  = (|bus.rn_valid) & rn_ready;
        for (int i = 0; i < IW; i++) begin
            lrs1[i]     = bus.rn_lrs1[i*REG_AW +: REG_AW];
            lrs2[i]     = bus.rn_lrs2[i*REG_AW +: REG_AW];
            lrd[i]      = bus.rn_lrd[i*REG_AW +: REG_AW];
            fl[i]       = bus.fl_prd[i*PRF_AW +: PRF_AW];
            lrd_we[i]   = bus.rn_lrd_we[i] & (lrd[i] != '0);
            pop[i]      = bus.rn_valid[i] & in_fire;
            rd_prs1[i]  = (lrs1[i] == '0) ? '0 : srat_q[lrs1[i]];
            rd_prs2[i]  = (lrs2[i] == '0) ? '0 : srat_q[lrs2[i]];
            rd_pfree[i] = srat_q[lrd[i]];
            prd_n[i]    = lrd_we[i] ? fl[i] : '0;
        end
        pfree_0 = lrd_we[0] ? rd_pfree[0] : '0;
    end

    rn_rat_bypass u_bypass (
        .valid0     (bus.rn_valid[0]),
        .lrd_we     (lrd_we[1:0]),
        .lrd0       (lrd[0]),
        .lrd1       (lrd[1]),
        .lrs1_1     (lrs1[1]),
        .lrs2_1     (lrs2[1]),
        .fl_prd0    (fl[0]),
        .rd_prs1_1  (rd_prs1[1]),
        .rd_prs2_1  (rd_prs2[1]),
        .rd_pfree_1 (rd_pfree[1]),
        .prs1_1     (prs1_1),
        .prs2_1     (prs2_1),
        .pfree_1    (pfree_1)
    );

    // Output stage: capture on fire, hold under backpressure, drop on rollback
    always_comb begin
        out_valid_d      = out_valid_q;
        out_prs1_d       = out_prs1_q;
        out_prs2_d       = out_prs2_q;
        out_prd_d        = out_prd_q;
        out_pfree_d      = out_pfree_q;
        out_prd_we_d     = out_prd_we_q;
        out_slot_valid_d = out_slot_valid_q;
        if (bus.rollback) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d      = 1'b1;
            out_prs1_d       = {prs1_1, rd_prs1[0]};
            out_prs2_d       = {prs2_1, rd_prs2[0]};
            out_prd_d        = {prd_n[1], prd_n[0]};
            out_pfree_d      = {pfree_1, pfree_0};
            out_prd_we_d     = lrd_we;
            out_slot_valid_d = bus.rn_valid;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Speculative map: rollback copies the pre-commit aRAT, else apply slot writes in order
    always_comb begin
        srat_d = srat_q;
        if (bus.rollback) begin
            srat_d = arat_q;
        end else if (in_fire) begin
            for (int i = 0; i < IW; i++) begin
                if (pop[i] && lrd_we[i]) begin
                    srat_d[lrd[i]] = fl[i];
                end
            end
        end
    end

    // Architectural map follows commits in ascending slot order, even during rollback
    always_comb begin
        arat_d = arat_q;
        for (int j = 0; j < CW; j++) begin
            if (bus.cmt_fire[j] && bus.cmt_prd_we[j]) begin
                arat_d[bus.cmt_lrd[j*REG_AW +: REG_AW]] = bus.cmt_prd[j*PRF_AW +: PRF_AW];
            end
        end
    end

    // State registers; reset maps every logical register to PR0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                srat_q[k] <= '0;
                arat_q[k] <= '0;
            end
            out_valid_q      <= 1'b0;
            out_prs1_q       <= '0;
            out_prs2_q       <= '0;
            out_prd_q        <= '0;
            out_pfree_q      <= '0;
            out_prd_we_q     <= '0;
            out_slot_valid_q <= '0;
        end else begin
            srat_q           <= srat_d;
            arat_q           <= arat_d;
            out_valid_q      <= out_valid_d;
            out_prs1_q       <= out_prs1_d;
            out_prs2_q       <= out_prs2_d;
            out_prd_q        <= out_prd_d;
            out_pfree_q      <= out_pfree_d;
            out_prd_we_q     <= out_prd_we_d;
            out_slot_valid_q <= out_slot_valid_d;
        end
    end

    assign bus.rn_ready       = rn_ready;
    assign bus.pop            = pop;
    assign bus.lrd_we         = lrd_we;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_prs1       = out_prs1_q;
    assign bus.out_prs2       = out_prs2_q;
    assign bus.out_prd        = out_prd_q;
    assign bus.out_pfree      = out_pfree_q;
    assign bus.out_prd_we     = out_prd_we_q;
    assign bus.out_slot_valid = out_slot_valid_q;

`ifndef SYNTHESIS
    a_iw_supported: assert property (@(posedge clk) IW == 2)
        else $fatal(1, "rn_rat supports only a rename width of 2");
    a_no_pop_on_stall: assert property (@(posedge clk) disable iff (rst)
        !(bus.fl_stall_req && (|bus.pop)));
    for (genvar j = 0; j < CW; j++) begin : g_cmt_chk
        a_cmt_not_r0: assert property (@(posedge clk) disable iff (rst)
            bus.cmt_prd_we[j] |-> (bus.cmt_lrd[j*REG_AW +: REG_AW] != '0));
    end
`endif
endmodule

// File: tb/tb_rn_rat.sv
// tb/tb_rn_rat.sv - directed table plus randomized reference-model bench for rn_rat
module tb_rn_rat;
    import rn_rat_pkg::*;

    localparam int IW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rn_rat_if #(.IW(IW), .CW(CW)) bus ();

    rn_rat #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]             valid;
        logic [1:0]             we;
        logic [1:0][REG_AW-1:0] lrs1;
        logic [1:0][REG_AW-1:0] lrs2;
        logic [1:0][REG_AW-1:0] lrd;
        logic [1:0][PRF_AW-1:0] fl;
        logic                   stall;
        logic                   ordy;
        logic                   rb;
        logic [1:0]             cfire;
        logic [1:0]             cwe;
        logic [1:0][REG_AW-1:0] clrd;
        logic [1:0][PRF_AW-1:0] cprd;
        logic                   e_ready;
        logic [1:0]             e_pop;
        logic [1:0]             e_lrdwe;
        logic                   e_ov;
        logic [1:0][PRF_AW-1:0] e_prs1;
        logic [1:0][PRF_AW-1:0] e_prs2;
        logic [1:0][PRF_AW-1:0] e_prd;
        logic [1:0][PRF_AW-1:0] e_pfree;
    } vec_t;

    // reference model: a map lookup done slot by slot in program order
    preg_t srat_m [NREG];
    preg_t arat_m [NREG];
    bit    m_ov;
    preg_t m_prs1 [2];
    preg_t m_prs2 [2];
    preg_t m_prd [2];
    preg_t m_pfree [2];
    logic [1:0] m_slot, m_we;

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) begin
            srat_m[k] = '0;
            arat_m[k] = '0;
        end
        m_ov = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.rn_valid     = v.valid;
        bus.rn_lrd_we    = v.we;
        bus.rn_lrs1      = v.lrs1;
        bus.rn_lrs2      = v.lrs2;
        bus.rn_lrd       = v.lrd;
        bus.fl_prd       = v.fl;
        bus.fl_stall_req = v.stall;
        bus.out_ready    = v.ordy;
        bus.rollback     = v.rb;
        bus.cmt_fire     = v.cfire;
        bus.cmt_prd_we   = v.cwe;
        bus.cmt_lrd      = v.clrd;
        bus.cmt_prd      = v.cprd;
    endtask

    task automatic apply(input vec_t v, input bit use_tab);
        logic [1:0] we_eff;
        bit    rdy, fire;
        preg_t tmp [NREG];
        drive(v);
        n_vec++;
        #1;
        for (int i = 0; i < 2; i++) we_eff[i] = v.we[i] && (v.lrd[i] != 0);
        rdy  = (!m_ov || v.ordy) && !v.stall && !v.rb;
        fire = (v.valid != 0) && rdy;
        chk("rn_ready", 32'(bus.rn_ready), 32'(rdy));
        chk("pop", 32'(bus.pop), fire ? 32'(v.valid) : 32'd0);
        chk("lrd_we", 32'(bus.lrd_we), 32'(we_eff));
        if (use_tab) begin
            chk("tab_rn_ready", 32'(bus.rn_ready), 32'(v.e_ready));
            chk("tab_pop", 32'(bus.pop), 32'(v.e_pop));
            chk("tab_lrd_we", 32'(bus.lrd_we), 32'(v.e_lrdwe));
        end
        if (v.rb) begin
            srat_m = arat_m;
            m_ov = 1'b0;
        end else if (fire) begin
            tmp = srat_m;
            for (int i = 0; i < 2; i++) begin
                if (v.valid[i]) begin
                    m_prs1[i] = tmp[v.lrs1[i]];
                    m_prs2[i] = tmp[v.lrs2[i]];
                    m_prd[i]  = '0;
                    m_pfree[i] = '0;
                    if (we_eff[i]) begin
                        m_pfree[i] = tmp[v.lrd[i]];
                        m_prd[i]   = v.fl[i];
                        tmp[v.lrd[i]] = v.fl[i];
                    end
                end
            end
            srat_m = tmp;
            m_ov   = 1'b1;
            m_slot = v.valid;
            m_we   = we_eff;
        end else if (v.ordy) begin
            m_ov = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            if (v.cfire[j] && v.cwe[j]) arat_m[v.clrd[j]] = v.cprd[j];
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_slot_valid", 32'(bus.out_slot_valid), 32'(m_slot));
            for (int i = 0; i < 2; i++) begin
                if (m_slot[i]) begin
                    chk($sformatf("prs1[%0d]", i), 32'(bus.out_prs1[i*PRF_AW +: PRF_AW]), 32'(m_prs1[i]));
                    chk($sformatf("prs2[%0d]", i), 32'(bus.out_prs2[i*PRF_AW +: PRF_AW]), 32'(m_prs2[i]));
                    chk($sformatf("prd[%0d]", i), 32'(bus.out_prd[i*PRF_AW +: PRF_AW]), 32'(m_prd[i]));
                    chk($sformatf("pfree[%0d]", i), 32'(bus.out_pfree[i*PRF_AW +: PRF_AW]), 32'(m_pfree[i]));
                    chk($sformatf("prd_we[%0d]", i), 32'(bus.out_prd_we[i]), 32'(m_we[i]));
                end
            end
        end
        if (use_tab) begin
            chk("tab_out_valid", 32'(bus.out_valid), 32'(v.e_ov));
            if (v.e_ov) begin
                chk("tab_prs1", 32'(bus.out_prs1), 32'(v.e_prs1));
                chk("tab_prs2", 32'(bus.out_prs2), 32'(v.e_prs2));
                chk("tab_prd", 32'(bus.out_prd), 32'(v.e_prd));
                chk("tab_pfree", 32'(bus.out_pfree), 32'(v.e_pfree));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_prd"}, 32'(bus.out_prd), 32'd0);
        chk({tag, "_out_prs1"}, 32'(bus.out_prs1), 32'd0);
        chk({tag, "_out_pfree"}, 32'(bus.out_pfree), 32'd0);
    endtask

    vec_t tv[$];
    vec_t v;
    vec_t idle;

    initial begin
        idle = '0;
        idle.ordy = 1'b1;
        drive(idle);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // r3 <- r1 + r2 with fl_prd = {7,5}
        v = '0; v.ordy = 1; v.valid = 2'b01; v.we = 2'b01;
        v.lrs1[0] = 1; v.lrs2[0] = 2; v.lrd[0] = 3; v.fl[0] = 5; v.fl[1] = 7;
        v.e_ready = 1; v.e_pop = 2'b01; v.e_lrdwe = 2'b01; v.e_ov = 1; v.e_prd[0] = 5;
        tv.push_back(v);
        // {r4 <- r3+r3 ; r5 <- r4+r0}, fl_prd = {9,8}
        v = '0; v.ordy = 1; v.valid = 2'b11; v.we = 2'b11;
        v.lrs1[0] = 3; v.lrs2[0] = 3; v.lrd[0] = 4; v.lrs1[1] = 4; v.lrs2[1] = 0; v.lrd[1] = 5;
        v.fl[0] = 8; v.fl[1] = 9;
        v.e_ready = 1; v.e_pop = 2'b11; v.e_lrdwe = 2'b11; v.e_ov = 1;
        v.e_prs1[0] = 5; v.e_prs1[1] = 8; v.e_prs2[0] = 5; v.e_prd[0] = 8; v.e_prd[1] = 9;
        tv.push_back(v);
        // r6 -> 2
        v = '0; v.ordy = 1; v.valid = 2'b01; v.we = 2'b01; v.lrd[0] = 6; v.fl[0] = 2;
        v.e_ready = 1; v.e_pop = 2'b01; v.e_lrdwe = 2'b01; v.e_ov = 1; v.e_prd[0] = 2;
        tv.push_back(v);
        // WAW {r6 ; r6}, fl_prd = {11,10}
        v = '0; v.ordy = 1; v.valid = 2'b11; v.we = 2'b11; v.lrd[0] = 6; v.lrd[1] = 6;
        v.fl[0] = 10; v.fl[1] = 11;
        v.e_ready = 1; v.e_pop = 2'b11; v.e_lrdwe = 2'b11; v.e_ov = 1;
        v.e_prd[0] = 10; v.e_prd[1] = 11; v.e_pfree[0] = 2; v.e_pfree[1] = 10;
        tv.push_back(v);
        // commit r6 -> 11 while renaming r6 -> 12
        v = '0; v.ordy = 1; v.valid = 2'b01; v.we = 2'b01; v.lrd[0] = 6; v.fl[0] = 12;
        v.cfire = 2'b01; v.cwe = 2'b01; v.clrd[0] = 6; v.cprd[0] = 11;
        v.e_ready = 1; v.e_pop = 2'b01; v.e_lrdwe = 2'b01; v.e_ov = 1;
        v.e_prd[0] = 12; v.e_pfree[0] = 11;
        tv.push_back(v);
        // rollback: no pop, output dropped
        v = '0; v.ordy = 1; v.rb = 1; v.valid = 2'b01; v.lrs1[0] = 6;
        tv.push_back(v);
        // r6 now reads 11, r3 rolled back to PR0
        v = '0; v.ordy = 1; v.valid = 2'b01; v.lrs1[0] = 6; v.lrs2[0] = 3;
        v.e_ready = 1; v.e_pop = 2'b01; v.e_ov = 1; v.e_prs1[0] = 11;
        tv.push_back(v);
        // downstream stall for 3 cycles: outputs stay put
        for (int k = 0; k < 3; k++) begin
            v = '0; v.valid = 2'b11; v.we = 2'b11; v.lrd[0] = 9; v.lrd[1] = 10;
            v.fl[0] = 20; v.fl[1] = 21;
            v.e_lrdwe = 2'b11; v.e_ov = 1; v.e_prs1[0] = 11;
            tv.push_back(v);
        end
        // release: a new group is taken the same cycle
        v = '0; v.ordy = 1; v.valid = 2'b01; v.we = 2'b01; v.lrd[0] = 7; v.lrs1[0] = 6; v.fl[0] = 13;
        v.e_ready = 1; v.e_pop = 2'b01; v.e_lrdwe = 2'b01; v.e_ov = 1;
        v.e_prs1[0] = 11; v.e_prd[0] = 13;
        tv.push_back(v);
        // free list stall: nothing popped, map untouched
        v = '0; v.ordy = 1; v.stall = 1; v.valid = 2'b11; v.we = 2'b11; v.lrd[0] = 7; v.lrd[1] = 8;
        v.fl[0] = 14; v.fl[1] = 15;
        v.e_lrdwe = 2'b11;
        tv.push_back(v);
        // r7/r8 unchanged; slot 1 writes r0 so lrd_we masks it and prd stays 0
        v = '0; v.ordy = 1; v.valid = 2'b11; v.we = 2'b10; v.lrs1[0] = 7; v.lrs2[0] = 8;
        v.lrs1[1] = 7; v.lrd[1] = 0; v.fl[1] = 16;
        v.e_ready = 1; v.e_pop = 2'b11; v.e_ov = 1; v.e_prs1[0] = 13; v.e_prs1[1] = 13;
        tv.push_back(v);

        foreach (tv[k]) apply(tv[k], 1'b1);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                rst = 1'b1;
                drive(idle);
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
                check_reset_state("midrst");
            end
            v = '0;
            v.valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                v.we[i]   = v.valid[i] & 1'($urandom_range(0, 1));
                v.lrs1[i] = REG_AW'($urandom_range(0, 7));
                v.lrs2[i] = REG_AW'($urandom_range(0, 7));
                v.lrd[i]  = REG_AW'($urandom_range(0, 7));
                v.fl[i]   = PRF_AW'($urandom_range(1, 63));
                v.cfire[i] = 1'($urandom_range(0, 1));
                v.cwe[i]   = 1'($urandom_range(0, 1));
                v.clrd[i]  = REG_AW'($urandom_range(1, 7));
                v.cprd[i]  = PRF_AW'($urandom_range(1, 63));
            end
            v.stall = ($urandom_range(0, 7) == 0);
            v.ordy  = ($urandom_range(0, 3) != 0);
            v.rb    = ($urandom_range(0, 19) == 0);
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
